// File: rtl/uart_apb_pkg.sv
// Shared constants and state encodings for the UART-to-APB debug bridge.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: command/reply byte codes, parser state enum, RX deserializer state enum.
package uart_apb_pkg;

  localparam logic [7:0] CMD_WRITE   = 8'h57;  // 'W'
  localparam logic [7:0] CMD_READ    = 8'h52;  // 'R'
  localparam logic [7:0] RSP_OK      = 8'h4B;  // 'K'
  localparam logic [7:0] RSP_ERR     = 8'h45;  // 'E'
  localparam logic [7:0] RSP_BAD     = 8'h3F;  // '?'
  localparam logic [7:0] RSP_TIMEOUT = 8'h54;  // 'T'

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA,
    SETUP,
    ACCESS,
    RESP
  } parser_state_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_BREAK
  } rx_state_e;

endpackage

// File: rtl/uart_apb_bridge_if.sv
// APB initiator/completer signal bundle used by the bridge.
// Latency: n/a (wires only).
// Backpressure: completer stalls the access phase by holding apb_ready low.
// master: drives sel/enable/write/addr/wdata, samples rdata/ready/slverr.
// slave : the mirror image, used by a completer or a testbench model.
interface uart_apb_bridge_if;
  logic        apb_sel;
  logic        apb_enable;
  logic        apb_write;
  logic [31:0] apb_addr;
  logic [31:0] apb_wdata;
  logic [31:0] apb_rdata;
  logic        apb_ready;
  logic        apb_slverr;

  modport master (
    output apb_sel, apb_enable, apb_write, apb_addr, apb_wdata,
    input  apb_rdata, apb_ready, apb_slverr
  );

  modport slave (
    input  apb_sel, apb_enable, apb_write, apb_addr, apb_wdata,
    output apb_rdata, apb_ready, apb_slverr
  );
endinterface

// File: rtl/uart_byte_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, half-bit start validation, LSB-first deserializer.
// Latency: byte_vld_o pulses one cycle after the stop-bit centre sample.
// Backpressure: none; the consumer must take the byte in its valid cycle or lose it.
// Ports: clk, reset (sync, active-low), rx_i (async serial in), byte_o, byte_vld_o, frm_err_o.
module uart_byte_rx
  import uart_apb_pkg::*;
#(
  parameter logic [15:0] DIVISOR = 16'd433
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_i,
  output logic [7:0] byte_o,
  output logic       byte_vld_o,
  output logic       frm_err_o
);

  localparam logic [15:0] HALF = DIVISOR >> 1;

  logic        rx_s1_q, rx_s2_q;
  rx_state_e   st_q, st_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  sh_q, sh_d;
  logic        vld_q, vld_d;
  logic        err_q, err_d;

  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    bit_d = bit_q;
    sh_d  = sh_q;
    vld_d = 1'b0;
    err_d = 1'b0;
    case (st_q)
      RX_IDLE: begin
        if (!rx_s2_q) begin
          cnt_d = '0;
          st_d  = RX_START;
        end
      end
      RX_START: begin
        // A low that does not survive to mid-bit is treated as line noise.
        if (cnt_q == HALF) begin
          cnt_d = '0;
          bit_d = '0;
          st_d  = rx_s2_q ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      RX_DATA: begin
        if (cnt_q == DIVISOR) begin
          cnt_d = '0;
          sh_d  = {rx_s2_q, sh_q[7:1]};
          if (bit_q == 3'd7) st_d = RX_STOP;
          else               bit_d = bit_q + 3'd1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      RX_STOP: begin
        if (cnt_q == DIVISOR) begin
          cnt_d = '0;
          if (rx_s2_q) begin
            vld_d = 1'b1;
            st_d  = RX_IDLE;
          end else begin
            err_d = 1'b1;
            st_d  = RX_BREAK;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      RX_BREAK: begin
        // After a bad stop bit, wait for the line to return high so the
        // tail of the low stop bit is not mistaken for a new start bit.
        if (rx_s2_q) st_d = RX_IDLE;
      end
      default: st_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
      st_q    <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      rx_s1_q <= rx_i;
      rx_s2_q <= rx_s1_q;
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
    end
  end

  assign byte_o     = sh_q;
  assign byte_vld_o = vld_q;
  assign frm_err_o  = err_q;

endmodule

// File: rtl/uart_apb_bridge.sv
// UART command bridge issuing single APB read/write transfers and replying on TX.
// Latency: SETUP one cycle after the last command byte; reply starts one cycle after apb_ready.
// Backpressure: access phase waits on apb_ready; bytes arriving during SETUP/ACCESS/RESP are dropped.
// Ports: clk, reset (sync, active-low), rx (serial in), tx (serial out), apb (initiator modport).
// Build option: define UART_APB_TIMEOUT_EN to add the ACCESS watchdog (TIMEOUT_CYCLES, 'T' reply).
module uart_apb_bridge
  import uart_apb_pkg::*;
#(
  parameter logic [15:0] DIVISOR = 16'd433
`ifdef UART_APB_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 1024
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx,
  output logic              tx,
  uart_apb_bridge_if.master apb
);

  logic [7:0] rx_byte;
  logic       rx_vld;
  logic       rx_err;

  uart_byte_rx #(.DIVISOR(DIVISOR)) u_rx (
    .clk       (clk),
    .reset     (reset),
    .rx_i      (rx),
    .byte_o    (rx_byte),
    .byte_vld_o(rx_vld),
    .frm_err_o (rx_err)
  );

  parser_state_e state_q, state_d;
  logic [1:0]    bcnt_q, bcnt_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          write_q, write_d;
  // Pending reply bytes, next byte to send in [7:0].
  logic [39:0]   rsp_q, rsp_d;
  logic [2:0]    rsp_cnt_q, rsp_cnt_d;
  // TX frame shifter; bit 0 is the line, idle shifts in ones.
  logic [9:0]    tx_sh_q, tx_sh_d;
  logic [3:0]    tx_bit_q, tx_bit_d;
  logic [15:0]   tx_baud_q, tx_baud_d;
  logic          tx_busy_q, tx_busy_d;
  logic          tx_done;

`ifdef UART_APB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  logic [TO_W-1:0] to_q, to_d;
`endif

  assign tx_done = tx_busy_q && (tx_baud_q == DIVISOR) && (tx_bit_q == 4'd9);

  always_comb begin
    state_d   = state_q;
    bcnt_d    = bcnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    write_d   = write_q;
    rsp_d     = rsp_q;
    rsp_cnt_d = rsp_cnt_q;
    tx_sh_d   = tx_sh_q;
    tx_bit_d  = tx_bit_q;
    tx_baud_d = tx_baud_q;
    tx_busy_d = tx_busy_q;
`ifdef UART_APB_TIMEOUT_EN
    to_d      = to_q;
`endif

    // TX serializer
    if (tx_busy_q) begin
      if (tx_baud_q == DIVISOR) begin
        tx_baud_d = '0;
        if (tx_bit_q == 4'd9) begin
          tx_busy_d = 1'b0;
          tx_sh_d   = '1;
        end else begin
          tx_sh_d  = {1'b1, tx_sh_q[9:1]};
          tx_bit_d = tx_bit_q + 4'd1;
        end
      end else begin
        tx_baud_d = tx_baud_q + 16'd1;
      end
    end

    // Reload on the last stop-bit cycle so consecutive bytes abut.
    if ((rsp_cnt_q != 3'd0) && (!tx_busy_q || tx_done)) begin
      tx_sh_d   = {1'b1, rsp_q[7:0], 1'b0};
      tx_busy_d = 1'b1;
      tx_bit_d  = '0;
      tx_baud_d = '0;
      rsp_d     = {8'h00, rsp_q[39:8]};
      rsp_cnt_d = rsp_cnt_q - 3'd1;
    end

    // Parser; a reply push below overrides the pop above.
    case (state_q)
      IDLE: begin
        if (rx_vld) begin
          if (rx_byte == CMD_WRITE || rx_byte == CMD_READ) begin
            write_d = (rx_byte == CMD_WRITE);
            bcnt_d  = '0;
            state_d = ADDR;
          end else begin
            rsp_d     = {32'h0, RSP_BAD};
            rsp_cnt_d = 3'd1;
          end
        end
      end
      ADDR: begin
        if (rx_vld) begin
          addr_d = {rx_byte, addr_q[31:8]};
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) state_d = write_q ? DATA : SETUP;
        end
      end
      DATA: begin
        if (rx_vld) begin
          wdata_d = {rx_byte, wdata_q[31:8]};
          bcnt_d  = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) state_d = SETUP;
        end
      end
      SETUP: begin
        state_d = ACCESS;
`ifdef UART_APB_TIMEOUT_EN
        to_d = '0;
`endif
      end
      ACCESS: begin
        if (apb.apb_ready) begin
          if (apb.apb_slverr) begin
            rsp_d     = {32'h0, RSP_ERR};
            rsp_cnt_d = 3'd1;
          end else if (write_q) begin
            rsp_d     = {32'h0, RSP_OK};
            rsp_cnt_d = 3'd1;
          end else begin
            rsp_d     = {apb.apb_rdata, RSP_OK};
            rsp_cnt_d = 3'd5;
          end
          state_d = RESP;
        end
`ifdef UART_APB_TIMEOUT_EN
        else if (to_q == TO_LAST) begin
          rsp_d     = {32'h0, RSP_TIMEOUT};
          rsp_cnt_d = 3'd1;
          state_d   = RESP;
        end else begin
          to_d = to_q + TO_W'(1);
        end
`endif
      end
      RESP: begin
        if (rsp_cnt_q == 3'd0 && !tx_busy_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A framing error abandons any half-received command.
    if (rx_err && (state_q == IDLE || state_q == ADDR || state_q == DATA)) begin
      state_d = IDLE;
      bcnt_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      bcnt_q    <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      write_q   <= 1'b0;
      rsp_q     <= '0;
      rsp_cnt_q <= '0;
      tx_sh_q   <= '1;
      tx_bit_q  <= '0;
      tx_baud_q <= '0;
      tx_busy_q <= 1'b0;
`ifdef UART_APB_TIMEOUT_EN
      to_q      <= '0;
`endif
    end else begin
      state_q   <= state_d;
      bcnt_q    <= bcnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      write_q   <= write_d;
      rsp_q     <= rsp_d;
      rsp_cnt_q <= rsp_cnt_d;
      tx_sh_q   <= tx_sh_d;
      tx_bit_q  <= tx_bit_d;
      tx_baud_q <= tx_baud_d;
      tx_busy_q <= tx_busy_d;
`ifdef UART_APB_TIMEOUT_EN
      to_q      <= to_d;
`endif
    end
  end

  assign apb.apb_sel    = (state_q == SETUP) || (state_q == ACCESS);
  assign apb.apb_enable = (state_q == ACCESS);
  assign apb.apb_write  = write_q;
  assign apb.apb_addr   = addr_q;
  assign apb.apb_wdata  = wdata_q;
  assign tx             = tx_sh_q[0];

endmodule

// File: tb/tb_uart_apb_bridge.sv
// Directed bench for uart_apb_bridge at DIVISOR=9 (10-cycle bits).
// Drives commands on rx, models an APB completer, decodes tx into a byte queue.
module tb_uart_apb_bridge;
  import uart_apb_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic rx = 1'b1;
  logic tx;

  uart_apb_bridge_if apb ();

  uart_apb_bridge #(
    .DIVISOR(16'd9)
`ifdef UART_APB_TIMEOUT_EN
    , .TIMEOUT_CYCLES(16)
`endif
  ) dut (
    .clk  (clk),
    .reset(reset),
    .rx   (rx),
    .tx   (tx),
    .apb  (apb)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests_run = 0;
  int tests_failed = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // APB completer model and access statistics
  int waits = 0;
  int acc_n = 0;
  int setup_n = 0, en_n = 0, xfer_n = 0, unstable_n = 0;
  logic [31:0] cap_addr = '0, cap_wdata = '0;
  logic cap_write = 1'b0;

  initial begin
    apb.apb_ready  = 1'b0;
    apb.apb_rdata  = '0;
    apb.apb_slverr = 1'b0;
    forever begin
      @(negedge clk);
      if (apb.apb_sel && !apb.apb_enable) begin
        setup_n++;
        cap_addr  = apb.apb_addr;
        cap_wdata = apb.apb_wdata;
        cap_write = apb.apb_write;
        acc_n     = 0;
      end
      if (apb.apb_sel && apb.apb_enable) begin
        en_n++;
        acc_n++;
        if (apb.apb_addr !== cap_addr || apb.apb_wdata !== cap_wdata ||
            apb.apb_write !== cap_write) unstable_n++;
      end
      apb.apb_ready = apb.apb_sel && apb.apb_enable && (acc_n > waits);
      if (apb.apb_ready) xfer_n++;
    end
  end

  // TX decoder: start seen at a negedge, bits sampled at their centres.
  logic [7:0] rxq[$];
  int stq[$];
  initial begin
    int st;
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (tx === 1'b0) begin
        st = cyc;
        repeat (5) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (10) @(negedge clk);
          b[i] = tx;
        end
        repeat (10) @(negedge clk);
        rxq.push_back(b);
        stq.push_back(st);
      end
    end
  end

  function automatic logic [7:0] q_at(input int i);
    if (i < rxq.size()) return rxq[i];
    return 8'hxx;
  endfunction

  task automatic uart_send(input logic [7:0] b, input logic stop_bit);
    @(negedge clk);
    rx = 1'b0;
    repeat (10) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (10) @(negedge clk);
    end
    rx = stop_bit;
    repeat (10) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic send_write(input logic [31:0] a, input logic [31:0] d);
    uart_send(CMD_WRITE, 1'b1);
    for (int i = 0; i < 4; i++) uart_send(a[8*i +: 8], 1'b1);
    for (int i = 0; i < 4; i++) uart_send(d[8*i +: 8], 1'b1);
  endtask

  task automatic send_read(input logic [31:0] a);
    uart_send(CMD_READ, 1'b1);
    for (int i = 0; i < 4; i++) uart_send(a[8*i +: 8], 1'b1);
  endtask

  task automatic wait_bytes(input string tag, input int n, input int limit);
    int k = 0;
    while (rxq.size() < n && k < limit) begin
      @(negedge clk);
      k++;
    end
    chk(tag, rxq.size(), n);
  endtask

  task automatic clear_q();
    rxq.delete();
    stq.delete();
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached, tests_run=%0d", tests_run);
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, e0, x0, u0, k;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_sel", apb.apb_sel, 0);
    chk("rst_en", apb.apb_enable, 0);
    chk("rst_write", apb.apb_write, 0);
    chk("rst_addr", apb.apb_addr, 0);
    chk("rst_wdata", apb.apb_wdata, 0);
    reset = 1'b1;
    repeat (5) @(negedge clk);

    // Write with 3 wait states
    waits = 3;
    s0 = setup_n; e0 = en_n; x0 = xfer_n; u0 = unstable_n;
    send_write(32'h4000_0010, 32'hDEAD_BEEF);
    wait_bytes("wr_rsp_cnt", 1, 3000);
    chk("wr_rsp", q_at(0), 8'h4B);
    chk("wr_setup_cycles", setup_n - s0, 1);
    chk("wr_en_cycles", en_n - e0, 4);
    chk("wr_xfers", xfer_n - x0, 1);
    chk("wr_addr", cap_addr, 32'h4000_0010);
    chk("wr_wdata", cap_wdata, 32'hDEAD_BEEF);
    chk("wr_write", cap_write, 1);
    chk("wr_stable", unstable_n - u0, 0);
    chk("wr_sel_after", apb.apb_sel, 0);
    chk("wr_addr_held", apb.apb_addr, 32'h4000_0010);
    clear_q();

    // Zero-wait read, back-to-back reply bytes
    waits = 0;
    apb.apb_rdata = 32'h1234_5678;
    s0 = setup_n; e0 = en_n;
    send_read(32'h4000_0004);
    wait_bytes("rd_rsp_cnt", 5, 3000);
    chk("rd_b0", q_at(0), 8'h4B);
    chk("rd_b1", q_at(1), 8'h78);
    chk("rd_b2", q_at(2), 8'h56);
    chk("rd_b3", q_at(3), 8'h34);
    chk("rd_b4", q_at(4), 8'h12);
    for (int i = 1; i < 5; i++)
      chk($sformatf("rd_gap%0d", i), (i < stq.size()) ? stq[i] - stq[i-1] : -1, 100);
    chk("rd_setup_cycles", setup_n - s0, 1);
    chk("rd_en_cycles", en_n - e0, 1);
    chk("rd_write", cap_write, 0);
    chk("rd_addr", cap_addr, 32'h4000_0004);
    chk("rd_wdata_held", apb.apb_wdata, 32'hDEAD_BEEF);
    clear_q();

    // Read with slave error, then a write
    waits = 1;
    apb.apb_slverr = 1'b1;
    e0 = en_n;
    send_read(32'h4000_0008);
    wait_bytes("err_rsp_cnt", 1, 3000);
    repeat (300) @(negedge clk);
    chk("err_only_one_byte", rxq.size(), 1);
    chk("err_rsp", q_at(0), 8'h45);
    chk("err_en_cycles", en_n - e0, 2);
    apb.apb_slverr = 1'b0;
    clear_q();
    send_write(32'h0000_0020, 32'h0000_0001);
    wait_bytes("post_err_wr_cnt", 1, 3000);
    chk("post_err_wr_rsp", q_at(0), 8'h4B);
    chk("post_err_wr_addr", cap_addr, 32'h0000_0020);
    chk("post_err_wr_wdata", cap_wdata, 32'h0000_0001);
    clear_q();

    // Bad command, framing error mid-address, then a valid write
    x0 = xfer_n;
    uart_send(8'h00, 1'b1);
    uart_send(CMD_READ, 1'b1);
    uart_send(8'h01, 1'b1);
    uart_send(8'h02, 1'b0);
    repeat (30) @(negedge clk);
    send_write(32'h0000_0030, 32'hCAFE_F00D);
    wait_bytes("fe_rsp_cnt", 2, 3000);
    chk("fe_bad_rsp", q_at(0), 8'h3F);
    chk("fe_wr_rsp", q_at(1), 8'h4B);
    chk("fe_xfers", xfer_n - x0, 1);
    chk("fe_addr", cap_addr, 32'h0000_0030);
    chk("fe_wdata", cap_wdata, 32'hCAFE_F00D);
    chk("fe_write", cap_write, 1);
    clear_q();

    // Two-cycle low glitch on an idle line
    x0 = xfer_n;
    @(negedge clk);
    rx = 1'b0;
    repeat (2) @(negedge clk);
    rx = 1'b1;
    repeat (300) @(negedge clk);
    chk("glitch_no_rsp", rxq.size(), 0);
    chk("glitch_no_xfer", xfer_n - x0, 0);

`ifdef UART_APB_TIMEOUT_EN
    // Completer never ready: watchdog ends the access
    waits = 100000;
    e0 = en_n;
    clear_q();
    send_read(32'h4000_0100);
    wait_bytes("to_rsp_cnt", 1, 3000);
    chk("to_rsp", q_at(0), 8'h54);
    chk("to_en_cycles", en_n - e0, 16);
    chk("to_sel_after", apb.apb_sel, 0);
    clear_q();
`endif

    // Reset in the middle of an ACCESS phase
    waits = 100000;
    clear_q();
    send_read(32'h4000_0040);
    k = 0;
    while (apb.apb_enable !== 1'b1 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk("rst_acc_en_seen", apb.apb_enable, 1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_acc_sel", apb.apb_sel, 0);
    chk("rst_acc_en", apb.apb_enable, 0);
    chk("rst_acc_tx", tx, 1);
    @(negedge clk);
    reset = 1'b1;
    repeat (300) @(negedge clk);
    chk("rst_acc_no_rsp", rxq.size(), 0);

    // Reset while '?' is on the wire truncates the frame
    waits = 0;
    clear_q();
    uart_send(8'h00, 1'b1);
    k = 0;
    while (tx !== 1'b0 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk("rst_tx_frame_seen", tx, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_tx_line_high", tx, 1);
    @(negedge clk);
    reset = 1'b1;
    repeat (300) @(negedge clk);
    clear_q();
    send_write(32'h0000_0050, 32'h5A5A_5A5A);
    wait_bytes("recover_rsp_cnt", 1, 3000);
    chk("recover_rsp", q_at(0), 8'h4B);
    chk("recover_addr", cap_addr, 32'h0000_0050);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/uart_apb_bridge.md
Name: uart_apb_bridge

Overview:
- Debug/boot bridge and the initiator end of the peripheral APB bus: receives 8N1 command frames on a serial line and issues single APB read/write transfers to peripherals.
- Returns status and read data on the serial TX line.
- Sits beside the CPU as a second APB initiator; arbitration is external. The bridge only drives the request and waits on apb_ready.

Parameters:
- DIVISOR, 16'd433, bit period minus one in clk cycles (bit period = DIVISOR+1).
- TIMEOUT_CYCLES, 1024, APB access watchdog limit; used only with the optional feature.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- rx  in  1  serial input, asynchronous, idle high
- tx  out  1  serial output, idle high
- apb_sel  out  1  transfer select
- apb_enable  out  1  access phase
- apb_write  out  1  1 = write
- apb_addr  out  32  address
- apb_wdata  out  32  write data
- apb_rdata  in  32  read data
- apb_ready  in  1  completer ready
- apb_slverr  in  1  completer error

Behaviour:
- Reset (reset==0 at posedge): tx=1, apb_sel=0, apb_enable=0, apb_write=0, apb_addr=0, apb_wdata=0, parser in IDLE, RX/TX serializers idle.
- RX path:
  - rx passes through a 2-flop synchronizer.
  - Start is detected on a synchronized 0, then re-checked at half bit (DIVISOR>>1 cycles). If rx is 1 at that point, treat it as a glitch and return to hunt.
  - 8 data bits (LSB first) are sampled at bit centres, then the stop bit.
  - Stop=0 is a framing error: the byte is dropped and the parser is forced to IDLE.
  - A byte becomes valid for one cycle after the stop sample.
- Command protocol (all multibyte fields LSB first):
  - 0x57 'W', then 4 address bytes, then 4 data bytes: APB write.
  - 0x52 'R', then 4 address bytes: APB read.
  - Any other first byte: reply 0x3F '?' and stay in IDLE.
- Parser FSM:
  - IDLE: 'W'/'R' go to ADDR; other bytes as above.
  - ADDR: counts bytes 0..3; after byte 3, 'R' goes to SETUP and 'W' goes to DATA.
  - DATA: counts bytes 0..3; after byte 3, goes to SETUP.
  - SETUP: apb_sel=1, apb_enable=0 for exactly one cycle, then ACCESS.
  - ACCESS: apb_sel=1, apb_enable=1, held until apb_ready=1. On that edge, capture apb_rdata/apb_slverr and drop apb_sel and apb_enable together. Then go to RESP.
  - RESP: the TX serializer sends the reply, then the FSM returns to IDLE.
- APB field stability:
  - apb_addr, apb_wdata and apb_write are loaded before SETUP and held constant through ACCESS.
  - They keep their values after the transfer; they are not cleared.
- Replies:
  - Write OK: 0x4B 'K'.
  - Read OK: 'K' followed by 4 rdata bytes, LSB first.
  - slverr: 0x45 'E' only; no data bytes.
- Half-duplex rule: bytes completing while in SETUP/ACCESS/RESP are discarded. The RX deserializer keeps running so framing stays aligned.
- TX:
  - Frame is start 0, 8 bits LSB first, stop 1; each bit lasts DIVISOR+1 cycles.
  - Back-to-back reply bytes have no idle gap beyond the stop bit.
  - tx=1 whenever idle.
- Boundary conditions:
  - Reset mid-transfer drops apb_sel/apb_enable at the next edge. No reply is sent, and a partial TX frame is truncated with tx=1.
  - apb_ready=1 in the first ACCESS cycle gives a zero-wait transfer: 2 cycles total with sel high.
  - A new start bit arriving during the TX of '?' is still received.

Optional Feature:
- Macro: UART_APB_TIMEOUT_EN.
- Defined:
  - A counter runs in ACCESS. If apb_ready is not seen within TIMEOUT_CYCLES cycles, apb_sel and apb_enable are dropped.
  - Reply is 0x54 'T' and the FSM returns to IDLE.
  - Counter width is $clog2(TIMEOUT_CYCLES+1).
- Undefined: ACCESS waits indefinitely; no counter logic is present.

Decomposition:
- Package uart_apb_pkg:
  - Byte constants CMD_WRITE=8'h57, CMD_READ=8'h52, RSP_OK=8'h4B, RSP_ERR=8'h45, RSP_BAD=8'h3F, RSP_TIMEOUT=8'h54.
  - Parser state enum typedef (IDLE, ADDR, DATA, SETUP, ACCESS, RESP).
- Sub-module uart_byte_rx: synchronizer, start validation, deserializer, framing check. Outputs byte plus a one-cycle valid.
- TX serializer and FSM stay in the top module.

Test Plan:
- DIVISOR=9; send 57 10 00 00 40 EF BE AD DE; completer ready after 3 waits -> one SETUP cycle, addr=0x40000010, wdata=0xDEADBEEF, apb_write=1, enable high 4 cycles; tx returns 4B.
- Send 52 04 00 00 40, apb_rdata=0x12345678, zero-wait -> SETUP then ACCESS 1 cycle; tx returns 4B 78 56 34 12 with no inter-byte gaps.
- Read with apb_slverr=1 -> tx returns 45 only; FSM back in IDLE, and a following write command succeeds.
- Send 0x00, then a frame with stop=0 mid-address, then a valid write -> tx '3F' for the first byte; the framing error resets the parser; the write completes with 4B.
- 2-cycle low glitch on idle rx -> no byte received, no APB activity.
- UART_APB_TIMEOUT_EN with TIMEOUT_CYCLES=16, apb_ready stuck 0 -> sel/enable drop after 16 ACCESS cycles, tx 54. Also assert reset mid-ACCESS -> sel=0 next edge, tx=1.
